board_disc_renderer: RTL and testbench
======================================

# board_disc_renderer

Parametrised, pipelined renderer for the Connect-4 board area of the VGA path. It tracks the raster position incrementally against a configurable grid of cells without dividers, and classifies each pixel as outside the board, board face, empty hole, red disc or yellow disc. Winning cells can be made to blink at a frame-counted rate. It sits between the VGA sync generator (PixelX/PixelY, pixel strobe, frame pulse) and the colour mux.

## Interface
- COLS, 7, board columns
- ROWS, 6, board rows
- CELL, 50, cell pitch in pixels (square cells, ≥ 2)
- X0, 145, PixelX of the board's left edge
- Y0, 90, PixelY of the board's top edge
- RADIUS, 20, disc radius in pixels (2*RADIUS ≤ CELL)
- BLINK_FRAMES, 30, frames per blink half-period (≥ 1)
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle strobe; PixelX/PixelY are valid for this pixel
- frame_start  in  1  one-cycle pulse, once per frame, independent of pix_en
- PixelX  in  10  current pixel column
- PixelY  in  10  current pixel row
- red_board  in  COLS*ROWS  bit i set = red disc in cell i
- yellow_board  in  COLS*ROWS  bit i set = yellow disc in cell i
- win_mask  in  COLS*ROWS  bit i set = cell i blinks
- in_board  out  1  pixel lies inside the board rectangle
- in_disc  out  1  pixel lies inside a cell's disc circle
- red  out  1  in_disc, cell red, not blanked
- yellow  out  1  in_disc, cell yellow, not red, not blanked
- hole  out  1  in_disc, cell empty or blanked
- highlight  out  1  in_disc, win_mask set for the cell
- cell_idx  out  $clog2(COLS*ROWS)  cell index of the pixel; 0 when outside the board

## Operation
- Cell index = row*COLS + col; row 0 is the top row, col 0 the leftmost column.
- Board rectangle: X0 ≤ PixelX < X0+COLS*CELL and Y0 ≤ PixelY < Y0+ROWS*CELL, by direct comparison.
- Horizontal tracker (col, xsub), updated on pix_en:
  - When PixelX == X0, the pixel is (0,0).
  - Otherwise xsub increments; on reaching CELL it wraps to 0 and col increments.
- Vertical tracker (row, ysub), updated on pix_en with PixelX == X0:
  - When PixelY == Y0, the line is (0,0).
  - Otherwise ysub increments with the same wrap into row.
- Trackers require raster order, with PixelX advancing by 1 per pix_en inside the board. Outputs are unspecified after a jump until the next line start. Trackers hold when outside the board.
- Disc test, exact integer arithmetic: dx = 2*xsub − (CELL−1) and dy = 2*ysub − (CELL−1), signed. in_disc = in_board & (dx² + dy² ≤ 4*RADIUS²). Intermediate widths must hold 2*(CELL−1)² without overflow.
- Priority: red over yellow when both bits are set.
- Blink:
  - Frame counter counts frame_start pulses 0..BLINK_FRAMES−1, then wraps and toggles blink_phase.
  - When blink_phase = 1, cells with win_mask set are blanked: red = yellow = 0, hole = 1, highlight stays 1.
- Outside the board, every output is 0.

## Timing
- Reset: all outputs 0, trackers 0, frame counter 0, blink_phase 0.
- Latency: outputs are registered and reflect the pix_en pixel one clk after the strobe. Without pix_en they hold.
- frame_start and pix_en in the same cycle: both take effect. The blink phase change applies to pixels strobed from the next cycle on.
- Board inputs are sampled in the pix_en cycle. Changes mid-frame take effect immediately, with no frame-boundary latching.
- Reset mid-line: all outputs go to 0 immediately. Tracking resumes correctly from the next line start (PixelX == X0) after release.

## Test plan
- Defaults; raster line at PixelY=115 (X from 140 to 500). Required:
  - X=144: in_board=0.
  - X=145: in_board=1, in_disc=0, cell_idx=0.
  - X=170: in_disc=1, hole=1.
  - X=495: in_board=0, cell_idx=0.
- red_board=1<<41; pixel (470,365) in raster order -> one clk later cell_idx=41, red=1, yellow=0, hole=0.
- red_board and yellow_board both bit 0; pixel (170,115) -> red=1, yellow=0.
- Disc edge, cell 0, line PixelY=115 (dy=1): X=150 (dx=−39) gives 1522 ≤ 1600 -> in_disc=1. X=149 (dx=−41) gives 1682 -> in_disc=0, in_board=1.
- yellow_board and win_mask bit 0; pixel (170,115):
  - Before 30 frame_start pulses: yellow=1, highlight=1.
  - After 30 pulses: yellow=0, hole=1, highlight=1.
  - After 60 pulses: yellow=1.
- Assert rst_n=0 at pixel (300,200) -> all outputs 0 asynchronously. Release, then run a full frame -> cell_idx and in_disc match the first scenario's values.

Source files
------------

// File: rtl/board_disc_renderer.sv
// rtl/board_disc_renderer.sv - Connect-4 board pixel classifier for the VGA path.
// Tracks raster position per cell incrementally and registers one classification per pixel strobe.
module board_disc_renderer #(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter int CELL         = 50,
  parameter int X0           = 145,
  parameter int Y0           = 90,
  parameter int RADIUS       = 20,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_en,
  input  logic                           frame_start,
  input  logic [9:0]                     PixelX,
  input  logic [9:0]                     PixelY,
  input  logic [COLS*ROWS-1:0]           red_board,
  input  logic [COLS*ROWS-1:0]           yellow_board,
  input  logic [COLS*ROWS-1:0]           win_mask,
  output logic                           in_board,
  output logic                           in_disc,
  output logic                           red,
  output logic                           yellow,
  output logic                           hole,
  output logic                           highlight,
  output logic [$clog2(COLS*ROWS)-1:0]   cell_idx
);

  localparam int NCELL = COLS * ROWS;
  localparam int IW    = $clog2(NCELL);
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int XW    = $clog2(CELL);
  localparam int DXW   = XW + 2;
  localparam int SW    = 2 * DXW;
  localparam int SW1   = SW + 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]            X_LO    = 11'(X0);
  localparam logic [10:0]            X_HI    = 11'(X0 + COLS * CELL);
  localparam logic [10:0]            Y_LO    = 11'(Y0);
  localparam logic [10:0]            Y_HI    = 11'(Y0 + ROWS * CELL);
  localparam logic [XW-1:0]          SUB_MAX = XW'(CELL - 1);
  localparam logic signed [DXW-1:0]  C_OFF   = DXW'(CELL - 1);
  localparam logic [SW1-1:0]         R_LIM   = SW1'(4 * RADIUS * RADIUS);
  localparam logic [FW-1:0]          FC_MAX  = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_col;
  logic [XW-1:0] r_xsub;
  logic [RW-1:0] r_row;
  logic [XW-1:0] r_ysub;
  logic [FW-1:0] r_fcnt;
  logic          r_blink;

  logic                  w_x_in;
  logic                  w_y_in;
  logic                  w_in_board;
  logic                  w_line_start;
  logic                  w_row_start;
  logic [CW-1:0]         w_col;
  logic [XW-1:0]         w_xsub;
  logic [RW-1:0]         w_row;
  logic [XW-1:0]         w_ysub;
  logic [IW-1:0]         w_idx;
  logic signed [DXW-1:0] w_dx;
  logic signed [DXW-1:0] w_dy;
  logic signed [SW-1:0]  w_dx_e;
  logic signed [SW-1:0]  w_dy_e;
  logic signed [SW-1:0]  w_dx2;
  logic signed [SW-1:0]  w_dy2;
  logic [SW1-1:0]        w_dist;
  logic                  w_disc;
  logic                  w_r;
  logic                  w_y;
  logic                  w_win;
  logic                  w_blank;

  assign w_x_in       = ({1'b0, PixelX} >= X_LO) && ({1'b0, PixelX} < X_HI);
  assign w_y_in       = ({1'b0, PixelY} >= Y_LO) && ({1'b0, PixelY} < Y_HI);
  assign w_in_board   = w_x_in && w_y_in;
  assign w_line_start = ({1'b0, PixelX} == X_LO);
  assign w_row_start  = ({1'b0, PixelY} == Y_LO);

  // Position of the current pixel, derived from the previous strobed pixel's position.
  always_comb begin
    w_col  = '0;
    w_xsub = '0;
    if (!w_line_start) begin
      if (r_xsub == SUB_MAX) begin
        w_col  = r_col + 1'b1;
        w_xsub = '0;
      end else begin
        w_col  = r_col;
        w_xsub = r_xsub + 1'b1;
      end
    end
  end

  always_comb begin
    w_row  = r_row;
    w_ysub = r_ysub;
    if (w_line_start) begin
      if (w_row_start) begin
        w_row  = '0;
        w_ysub = '0;
      end else if (r_ysub == SUB_MAX) begin
        w_row  = r_row + 1'b1;
        w_ysub = '0;
      end else begin
        w_ysub = r_ysub + 1'b1;
      end
    end
  end

  assign w_idx = IW'(w_row) * IW'(COLS) + IW'(w_col);

  // Doubled offsets from the cell centre keep the circle test in exact integers.
  assign w_dx   = $signed({1'b0, w_xsub, 1'b0}) - C_OFF;
  assign w_dy   = $signed({1'b0, w_ysub, 1'b0}) - C_OFF;
  assign w_dx_e = SW'(w_dx);
  assign w_dy_e = SW'(w_dy);
  assign w_dx2  = w_dx_e * w_dx_e;
  assign w_dy2  = w_dy_e * w_dy_e;
  assign w_dist = {1'b0, w_dx2} + {1'b0, w_dy2};
  assign w_disc = w_in_board && (w_dist <= R_LIM);

  assign w_r     = w_in_board && red_board[w_idx];
  assign w_y     = w_in_board && yellow_board[w_idx];
  assign w_win   = w_in_board && win_mask[w_idx];
  assign w_blank = r_blink && w_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_xsub <= '0;
      r_row  <= '0;
      r_ysub <= '0;
    end else if (pix_en && w_in_board) begin
      r_col  <= w_col;
      r_xsub <= w_xsub;
      r_row  <= w_row;
      r_ysub <= w_ysub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_blink <= 1'b0;
    end else if (frame_start) begin
      if (r_fcnt == FC_MAX) begin
        r_fcnt  <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_board  <= 1'b0;
      in_disc   <= 1'b0;
      red       <= 1'b0;
      yellow    <= 1'b0;
      hole      <= 1'b0;
      highlight <= 1'b0;
      cell_idx  <= '0;
    end else if (pix_en) begin
      in_board  <= w_in_board;
      in_disc   <= w_disc;
      red       <= w_disc && w_r && !w_blank;
      yellow    <= w_disc && w_y && !w_r && !w_blank;
      hole      <= w_disc && ((!w_r && !w_y) || w_blank);
      highlight <= w_disc && w_win;
      cell_idx  <= w_in_board ? w_idx : '0;
    end
  end

endmodule

// File: tb/tb_board_disc_renderer.sv
// tb/tb_board_disc_renderer.sv - directed bench for board_disc_renderer.
// Raster walks strobe PixelX == X0 on each line above the target, then sweep the target line.
module tb_board_disc_renderer;

  localparam int X0 = 145;
  localparam int Y0 = 90;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic        frame_start;
  logic [9:0]  PixelX;
  logic [9:0]  PixelY;
  logic [41:0] red_board;
  logic [41:0] yellow_board;
  logic [41:0] win_mask;
  logic        in_board;
  logic        in_disc;
  logic        red;
  logic        yellow;
  logic        hole;
  logic        highlight;
  logic [5:0]  cell_idx;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  board_disc_renderer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_en       (pix_en),
    .frame_start  (frame_start),
    .PixelX       (PixelX),
    .PixelY       (PixelY),
    .red_board    (red_board),
    .yellow_board (yellow_board),
    .win_mask     (win_mask),
    .in_board     (in_board),
    .in_disc      (in_disc),
    .red          (red),
    .yellow       (yellow),
    .hole         (hole),
    .highlight    (highlight),
    .cell_idx     (cell_idx)
  );

  function automatic logic [11:0] pk(input logic b, input logic d, input logic r,
                                     input logic y, input logic h, input logic hl,
                                     input int idx);
    return {b, d, r, y, h, hl, 6'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [11:0] e);
    logic [11:0] o;
    o = {in_board, in_disc, red, yellow, hole, highlight, cell_idx};
    vectors++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed {brd,dsc,r,y,hole,hl,idx}=%b expected %b", tag, o, e);
    end
  endtask

  task automatic strobe(input int x, input int y);
    @(negedge clk);
    PixelX = 10'(x);
    PixelY = 10'(y);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic walk_to(input int x, input int y);
    for (int yy = Y0; yy < y; yy++) strobe(X0, yy);
    for (int xx = X0; xx <= x; xx++) strobe(xx, y);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  task automatic line115(input string pfx);
    for (int yy = Y0; yy < 115; yy++) strobe(X0, yy);
    for (int xx = 140; xx <= 500; xx++) begin
      strobe(xx, 115);
      case (xx)
        144: chk({pfx, "x144"}, pk(0, 0, 0, 0, 0, 0, 0));
        145: chk({pfx, "x145"}, pk(1, 0, 0, 0, 0, 0, 0));
        149: chk({pfx, "x149_edge_out"}, pk(1, 0, 0, 0, 0, 0, 0));
        150: chk({pfx, "x150_edge_in"}, pk(1, 1, 0, 0, 1, 0, 0));
        170: chk({pfx, "x170"}, pk(1, 1, 0, 0, 1, 0, 0));
        495: chk({pfx, "x495"}, pk(0, 0, 0, 0, 0, 0, 0));
        default: ;
      endcase
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    pix_en       = 1'b0;
    frame_start  = 1'b0;
    PixelX       = '0;
    PixelY       = '0;
    red_board    = '0;
    yellow_board = '0;
    win_mask     = '0;
    repeat (3) @(negedge clk);
    chk("reset", pk(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    line115("l115_");

    red_board = 42'd1 << 41;
    walk_to(470, 365);
    chk("red41", pk(1, 1, 1, 0, 0, 0, 41));

    red_board    = 42'd1;
    yellow_board = 42'd1;
    walk_to(170, 115);
    chk("red_over_yellow", pk(1, 1, 1, 0, 0, 0, 0));

    red_board    = '0;
    yellow_board = 42'd1;
    win_mask     = 42'd1;
    walk_to(170, 115);
    chk("blink_f0", pk(1, 1, 0, 1, 0, 1, 0));
    frames(29);
    walk_to(170, 115);
    chk("blink_f29", pk(1, 1, 0, 1, 0, 1, 0));
    frames(1);
    walk_to(170, 115);
    chk("blink_f30", pk(1, 1, 0, 0, 1, 1, 0));
    frames(30);
    walk_to(170, 115);
    chk("blink_f60", pk(1, 1, 0, 1, 0, 1, 0));

    yellow_board = '0;
    win_mask     = '0;
    walk_to(300, 200);
    chk("pre_reset_300_200", pk(1, 0, 0, 0, 0, 0, 17));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", pk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    line115("post_rst_");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
